// File: rtl/spwm_phase_sequencer_if.sv
// Bus between the SPWM phase sequencer and its controller: run request, frequency
// word, the external sine look-up (address out, sample in) and the gate/status outputs.
interface spwm_phase_sequencer_if;
  logic        en;
  logic [15:0] freq_word;
  logic [11:0] sine_a;
  logic [11:0] sine_b;
  logic [7:0]  teth_ta;
  logic [7:0]  teth_tb;
  logic        pwm_a;
  logic        pwm_b;
  logic        busy;
  logic        cycle_done;

  modport master (
    output en, freq_word, sine_a, sine_b,
    input  teth_ta, teth_tb, pwm_a, pwm_b, busy, cycle_done
  );

  modport slave (
    input  en, freq_word, sine_a, sine_b,
    output teth_ta, teth_tb, pwm_a, pwm_b, busy, cycle_done
  );
endinterface

// File: rtl/spwm_phase_sequencer.sv
// Two-leg sinusoidal PWM sequencer: a carrier counter compares against per-period
// duty samples fetched from a sine table addressed by a 16-bit phase accumulator.
module spwm_phase_sequencer #(
  parameter logic [11:0] CARR_TOP = 12'd3711
) (
  input logic                    clk,
  input logic                    rst,
  spwm_phase_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state;
  logic [15:0] acc;
  logic [15:0] inc_reg;
  logic [11:0] cnt;
  logic [11:0] duty_a;
  logic [11:0] duty_b;
  logic        pwm_a;
  logic        pwm_b;
  logic        busy;
  logic        cycle_done;

  logic [16:0] acc_sum;
  logic        carr_end;
  logic        wrap;

  // Phase advances once per carrier period; its carry marks a fundamental cycle.
  assign acc_sum  = {1'b0, acc} + {1'b0, inc_reg};
  assign carr_end = (cnt == CARR_TOP);
  assign wrap     = carr_end & acc_sum[16];

  assign bus.teth_ta    = acc[15:8];
  assign bus.teth_tb    = acc[15:8] + 8'd128;
  assign bus.pwm_a      = pwm_a;
  assign bus.pwm_b      = pwm_b;
  assign bus.busy       = busy;
  assign bus.cycle_done = cycle_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= 16'd0;
      inc_reg    <= 16'd0;
      cnt        <= 12'd0;
      duty_a     <= 12'd0;
      duty_b     <= 12'd0;
      pwm_a      <= 1'b0;
      pwm_b      <= 1'b0;
      busy       <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      busy       <= (state != IDLE);
      cycle_done <= 1'b0;
      case (state)
        IDLE: begin
          acc    <= 16'd0;
          cnt    <= 12'd0;
          duty_a <= 12'd0;
          duty_b <= 12'd0;
          pwm_a  <= 1'b0;
          pwm_b  <= 1'b0;
          if (bus.en && (bus.freq_word != 16'd0)) begin
            inc_reg <= bus.freq_word;
            state   <= RUN;
          end
        end
        RUN, DRAIN: begin
          cnt <= carr_end ? 12'd0 : cnt + 12'd1;
          if (carr_end) acc <= acc_sum[15:0];
          // Duty is only resampled at the start of a carrier period to avoid glitches.
          if (cnt == 12'd0) begin
            duty_a <= bus.sine_a;
            duty_b <= bus.sine_b;
          end
          pwm_a <= (cnt < duty_a);
          pwm_b <= (cnt < duty_b);
          if (wrap) begin
            cycle_done <= 1'b1;
            inc_reg    <= bus.freq_word;
          end
          if (state == RUN) begin
            if (!bus.en) state <= DRAIN;
          end else if (bus.en) begin
            state <= RUN;
          end else if (wrap) begin
            // Finish on a whole fundamental cycle, leaving the gates off.
            state  <= IDLE;
            acc    <= 16'd0;
            cnt    <= 12'd0;
            duty_a <= 12'd0;
            duty_b <= 12'd0;
            pwm_a  <= 1'b0;
            pwm_b  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spwm_phase_sequencer.sv
// Directed bench for spwm_phase_sequencer using a small half-wave sine table:
// address 192 -> 3710, other addresses >= 128 -> 1000, addresses below 128 -> 0.
module tb_spwm_phase_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  spwm_phase_sequencer_if bus ();

  spwm_phase_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] lut(input logic [7:0] addr);
    if (addr == 8'd192) return 12'd3710;
    else if (addr[7])   return 12'd1000;
    else                return 12'd0;
  endfunction

  always_comb begin
    bus.sine_a = lut(bus.teth_ta);
    bus.sine_b = lut(bus.teth_tb);
  end

  task automatic advance_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.freq_word = 16'd0;
    repeat (3) @(negedge clk);
    total++; if (bus.teth_ta !== 8'd0)   begin bad++; $display("[TB] FAIL reset_teth_ta: got %0d want 0", bus.teth_ta); end
    total++; if (bus.teth_tb !== 8'd128) begin bad++; $display("[TB] FAIL reset_teth_tb: got %0d want 128", bus.teth_tb); end
    total++; if (bus.pwm_a !== 1'b0)     begin bad++; $display("[TB] FAIL reset_pwm_a: got %0d want 0", bus.pwm_a); end
    total++; if (bus.pwm_b !== 1'b0)     begin bad++; $display("[TB] FAIL reset_pwm_b: got %0d want 0", bus.pwm_b); end
    total++; if (bus.busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset_busy: got %0d want 0", bus.busy); end
    total++; if (bus.cycle_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_cycle_done: got %0d want 0", bus.cycle_done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_after_reset_busy: got %0d want 0", bus.busy); end
  endtask

  task automatic test_zero_freq();
    bus.en = 1'b1; bus.freq_word = 16'd0;
    repeat (20) @(negedge clk);
    total++; if (bus.busy !== 1'b0)   begin bad++; $display("[TB] FAIL zero_freq_busy: got %0d want 0", bus.busy); end
    total++; if (bus.pwm_a !== 1'b0)  begin bad++; $display("[TB] FAIL zero_freq_pwm_a: got %0d want 0", bus.pwm_a); end
    total++; if (bus.pwm_b !== 1'b0)  begin bad++; $display("[TB] FAIL zero_freq_pwm_b: got %0d want 0", bus.pwm_b); end
    total++; if (bus.teth_ta !== 8'd0) begin bad++; $display("[TB] FAIL zero_freq_teth_ta: got %0d want 0", bus.teth_ta); end
    bus.en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sequence();
    int exp_ta[5];
    int exp_tb[5];
    int want_hi_a[4];
    int want_hi_b[4];
    int hi_a[4];
    int hi_b[4];
    int pulses;
    int k;
    exp_ta = '{0, 64, 128, 192, 0};
    exp_tb = '{128, 192, 0, 64, 128};
    want_hi_a = '{0, 0, 1000, 3710};
    want_hi_b = '{1000, 3710, 0, 0};
    hi_a = '{default: 0};
    hi_b = '{default: 0};
    pulses = 0;
    bus.en = 1'b1; bus.freq_word = 16'h4000;
    @(negedge clk);
    cyc = 0;
    total++; if (bus.teth_ta !== 8'd0) begin bad++; $display("[TB] FAIL start_teth_ta: got %0d want 0", bus.teth_ta); end
    total++; if (bus.busy !== 1'b0)    begin bad++; $display("[TB] FAIL start_busy_delay: got %0d want 0", bus.busy); end
    for (int n = 1; n <= 14849; n++) begin
      @(negedge clk);
      cyc = n;
      if (n == 1) begin
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL start_busy: got %0d want 1", bus.busy); end
      end
      if (n >= 2) begin
        k = (n - 2) / 3712;
        hi_a[k] += int'(bus.pwm_a);
        hi_b[k] += int'(bus.pwm_b);
      end
      pulses += int'(bus.cycle_done);
      if (n % 3712 == 3711) begin
        total++; if (int'(bus.teth_ta) != exp_ta[n / 3712]) begin bad++; $display("[TB] FAIL seq_hold_ta@%0d: got %0d want %0d", n, bus.teth_ta, exp_ta[n / 3712]); end
      end
      if (n % 3712 == 0) begin
        total++; if (int'(bus.teth_ta) != exp_ta[n / 3712]) begin bad++; $display("[TB] FAIL seq_step_ta@%0d: got %0d want %0d", n, bus.teth_ta, exp_ta[n / 3712]); end
        total++; if (int'(bus.teth_tb) != exp_tb[n / 3712]) begin bad++; $display("[TB] FAIL seq_step_tb@%0d: got %0d want %0d", n, bus.teth_tb, exp_tb[n / 3712]); end
      end
      if (n == 14848) begin
        total++; if (bus.cycle_done !== 1'b1) begin bad++; $display("[TB] FAIL seq_cycle_done: got %0d want 1", bus.cycle_done); end
      end
    end
    total++; if (pulses != 1) begin bad++; $display("[TB] FAIL seq_pulse_count: got %0d want 1", pulses); end
    for (int p = 0; p < 4; p++) begin
      total++; if (hi_a[p] != want_hi_a[p]) begin bad++; $display("[TB] FAIL pwm_a_high_p%0d: got %0d want %0d", p, hi_a[p], want_hi_a[p]); end
      total++; if (hi_b[p] != want_hi_b[p]) begin bad++; $display("[TB] FAIL pwm_b_high_p%0d: got %0d want %0d", p, hi_b[p], want_hi_b[p]); end
    end
  endtask

  task automatic test_freq_change();
    int pts[8];
    int ta[8];
    int cd[8];
    pts = '{22271, 22272, 25983, 25984, 29695, 29696, 33407, 33408};
    ta  = '{64, 128, 128, 192, 192, 0, 0, 128};
    cd  = '{0, 0, 0, 0, 0, 1, 0, 0};
    advance_to(18600);
    total++; if (bus.teth_ta !== 8'd64) begin bad++; $display("[TB] FAIL fchg_pre_ta: got %0d want 64", bus.teth_ta); end
    bus.freq_word = 16'h8000;
    for (int i = 0; i < 8; i++) begin
      advance_to(pts[i]);
      total++; if (int'(bus.teth_ta) != ta[i]) begin bad++; $display("[TB] FAIL fchg_ta@%0d: got %0d want %0d", pts[i], bus.teth_ta, ta[i]); end
      total++; if (int'(bus.cycle_done) != cd[i]) begin bad++; $display("[TB] FAIL fchg_cd@%0d: got %0d want %0d", pts[i], bus.cycle_done, cd[i]); end
    end
    advance_to(33500);
    bus.freq_word = 16'h4000;
    advance_to(37119);
    total++; if (bus.teth_ta !== 8'd128) begin bad++; $display("[TB] FAIL fchg_ta@37119: got %0d want 128", bus.teth_ta); end
    advance_to(37120);
    total++; if (bus.teth_ta !== 8'd0)      begin bad++; $display("[TB] FAIL fchg_ta@37120: got %0d want 0", bus.teth_ta); end
    total++; if (bus.cycle_done !== 1'b1)   begin bad++; $display("[TB] FAIL fchg_cd@37120: got %0d want 1", bus.cycle_done); end
  endtask

  task automatic test_drain_stop();
    advance_to(40832);
    total++; if (bus.teth_ta !== 8'd64)  begin bad++; $display("[TB] FAIL drain_ta@40832: got %0d want 64", bus.teth_ta); end
    advance_to(44544);
    total++; if (bus.teth_ta !== 8'd128) begin bad++; $display("[TB] FAIL drain_ta@44544: got %0d want 128", bus.teth_ta); end
    advance_to(44600);
    bus.en = 1'b0;
    advance_to(44610);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL drain_busy@44610: got %0d want 1", bus.busy); end
    advance_to(48256);
    total++; if (bus.teth_ta !== 8'd192) begin bad++; $display("[TB] FAIL drain_ta@48256: got %0d want 192", bus.teth_ta); end
    advance_to(51967);
    total++; if (bus.busy !== 1'b1)       begin bad++; $display("[TB] FAIL drain_busy@51967: got %0d want 1", bus.busy); end
    total++; if (bus.cycle_done !== 1'b0) begin bad++; $display("[TB] FAIL drain_cd@51967: got %0d want 0", bus.cycle_done); end
    advance_to(51968);
    total++; if (bus.teth_ta !== 8'd0)    begin bad++; $display("[TB] FAIL drain_wrap_ta: got %0d want 0", bus.teth_ta); end
    total++; if (bus.teth_tb !== 8'd128)  begin bad++; $display("[TB] FAIL drain_wrap_tb: got %0d want 128", bus.teth_tb); end
    total++; if (bus.cycle_done !== 1'b1) begin bad++; $display("[TB] FAIL drain_wrap_cd: got %0d want 1", bus.cycle_done); end
    total++; if (bus.pwm_a !== 1'b0)      begin bad++; $display("[TB] FAIL drain_wrap_pwm_a: got %0d want 0", bus.pwm_a); end
    total++; if (bus.pwm_b !== 1'b0)      begin bad++; $display("[TB] FAIL drain_wrap_pwm_b: got %0d want 0", bus.pwm_b); end
    total++; if (bus.busy !== 1'b1)       begin bad++; $display("[TB] FAIL drain_wrap_busy: got %0d want 1", bus.busy); end
    advance_to(51969);
    total++; if (bus.busy !== 1'b0)       begin bad++; $display("[TB] FAIL drain_idle_busy: got %0d want 0", bus.busy); end
    total++; if (bus.cycle_done !== 1'b0) begin bad++; $display("[TB] FAIL drain_idle_cd: got %0d want 0", bus.cycle_done); end
    advance_to(52000);
    total++; if (bus.busy !== 1'b0)    begin bad++; $display("[TB] FAIL idle_hold_busy: got %0d want 0", bus.busy); end
    total++; if (bus.teth_ta !== 8'd0) begin bad++; $display("[TB] FAIL idle_hold_ta: got %0d want 0", bus.teth_ta); end
    total++; if (bus.pwm_b !== 1'b0)   begin bad++; $display("[TB] FAIL idle_hold_pwm_b: got %0d want 0", bus.pwm_b); end
  endtask

  task automatic test_reset_mid_run();
    bus.en = 1'b1; bus.freq_word = 16'h4000;
    @(negedge clk);
    cyc = 0;
    advance_to(1000);
    total++; if (bus.busy !== 1'b1)  begin bad++; $display("[TB] FAIL midrun_busy: got %0d want 1", bus.busy); end
    total++; if (bus.pwm_b !== 1'b1) begin bad++; $display("[TB] FAIL midrun_pwm_b: got %0d want 1", bus.pwm_b); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.teth_ta !== 8'd0)    begin bad++; $display("[TB] FAIL rst_mid_ta: got %0d want 0", bus.teth_ta); end
    total++; if (bus.teth_tb !== 8'd128)  begin bad++; $display("[TB] FAIL rst_mid_tb: got %0d want 128", bus.teth_tb); end
    total++; if (bus.pwm_b !== 1'b0)      begin bad++; $display("[TB] FAIL rst_mid_pwm_b: got %0d want 0", bus.pwm_b); end
    total++; if (bus.busy !== 1'b0)       begin bad++; $display("[TB] FAIL rst_mid_busy: got %0d want 0", bus.busy); end
    total++; if (bus.cycle_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_cd: got %0d want 0", bus.cycle_done); end
    rst = 1'b0;
    @(negedge clk);
    cyc = 0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL restart_busy0: got %0d want 0", bus.busy); end
    advance_to(1);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL restart_busy1: got %0d want 1", bus.busy); end
    advance_to(3711);
    total++; if (bus.teth_ta !== 8'd0)  begin bad++; $display("[TB] FAIL restart_ta@3711: got %0d want 0", bus.teth_ta); end
    advance_to(3712);
    total++; if (bus.teth_ta !== 8'd64) begin bad++; $display("[TB] FAIL restart_ta@3712: got %0d want 64", bus.teth_ta); end
  endtask

  task automatic test_drain_resume();
    advance_to(3720);
    bus.en = 1'b0;
    advance_to(3730);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL resume_drain_busy: got %0d want 1", bus.busy); end
    bus.en = 1'b1;
    advance_to(7423);
    total++; if (bus.teth_ta !== 8'd64)  begin bad++; $display("[TB] FAIL resume_ta@7423: got %0d want 64", bus.teth_ta); end
    advance_to(7424);
    total++; if (bus.teth_ta !== 8'd128) begin bad++; $display("[TB] FAIL resume_ta@7424: got %0d want 128", bus.teth_ta); end
    total++; if (bus.busy !== 1'b1)      begin bad++; $display("[TB] FAIL resume_busy: got %0d want 1", bus.busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.en        = 1'b0;
    bus.freq_word = 16'd0;
    $display("[TB] starting spwm_phase_sequencer bench");
    test_reset();
    test_zero_freq();
    test_sequence();
    test_freq_change();
    test_drain_stop();
    test_reset_mid_run();
    test_drain_resume();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
